reg_wb_arbiter: RTL and testbench

//   Shares the single write port of the 2R1W register file among NUM_REQ write-back

---
 rtl/reg_wb_arbiter_pkg.sv | 7 +
 rtl/reg_wb_arbiter_rr_arbiter.sv | 34 +++
 rtl/reg_wb_arbiter.sv | 98 +++++++++
 tb/tb_reg_wb_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// Shared register-file geometry for the write-back path.
// These values must match the register file configuration.
package reg_wb_arbiter_pkg;
    localparam int unsigned RF_DATA_WIDTH = 32;
    localparam int unsigned RF_ADDR_WIDTH = 5;
    localparam int unsigned RF_NUM_REQ    = 3;
endpackage

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first valid requester
// at or after ptr, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int unsigned NUM_REQ   = 3,
    parameter int unsigned PTR_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   valid,
    input  logic [PTR_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant
);

    always_comb begin
        logic                 found;
        logic [PTR_WIDTH:0]   sum;
        logic [PTR_WIDTH-1:0] idx;
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // ptr + k reduced modulo NUM_REQ; one subtract suffices since both are < NUM_REQ
            sum = {1'b0, ptr} + (PTR_WIDTH+1)'(k);
            if (sum >= (PTR_WIDTH+1)'(NUM_REQ)) begin
                sum = sum - (PTR_WIDTH+1)'(NUM_REQ);
            end
            idx = sum[PTR_WIDTH-1:0];
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin write-back arbiter for the single register-file write port,
// with a per-register busy scoreboard queried by issue/decode.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = RF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_waddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
    output logic                             rf_wen,
    output logic [ADDR_WIDTH-1:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0]            rf_wdata,
    input  logic                             issue_valid,
    input  logic [ADDR_WIDTH-1:0]            issue_waddr,
    input  logic [ADDR_WIDTH-1:0]            raddr1,
    input  logic [ADDR_WIDTH-1:0]            raddr2,
    output logic                             busy1,
    output logic                             busy2
);

    localparam int unsigned PTR_WIDTH = $clog2(NUM_REQ);
    localparam int unsigned NUM_REG   = 2**ADDR_WIDTH;

    logic [PTR_WIDTH-1:0]  rr_ptr;
    logic [PTR_WIDTH-1:0]  next_ptr;
    logic [NUM_REQ-1:0]    grant;
    logic [PTR_WIDTH-1:0]  sel_idx;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  transfer;
    logic [NUM_REG-1:0]    busy;
    logic [NUM_REG-1:0]    busy_next;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_rr_arbiter (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign req_ready = rst ? '0 : grant;
    assign transfer  = |(req_valid & req_ready);

    always_comb begin
        sel_idx  = '0;
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_idx  = PTR_WIDTH'(i);
                sel_addr = req_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        next_ptr = (sel_idx == PTR_WIDTH'(NUM_REQ-1)) ? '0 : sel_idx + 1'b1;
    end

    // Set after clear so a same-edge issue keeps the newer producer pending
    always_comb begin
        busy_next = busy;
        if (rf_wen) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (issue_valid && (issue_waddr != '0)) begin
            busy_next[issue_waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            rr_ptr   <= '0;
            busy     <= '0;
        end else begin
            rf_wen <= transfer && (sel_addr != '0);
            if (transfer) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
                rr_ptr   <= next_ptr;
            end
            busy <= busy_next;
        end
    end

    assign busy1 = busy[raddr1];
    assign busy2 = busy[raddr2];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: stimulus pushes expected grants/writes,
// a negedge monitor pops and compares them.
module tb_reg_wb_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_waddr;
    logic [NR*DW-1:0]  req_wdata;
    logic              rf_wen;
    logic [AW-1:0]     rf_waddr;
    logic [DW-1:0]     rf_wdata;
    logic              issue_valid;
    logic [AW-1:0]     issue_waddr;
    logic [AW-1:0]     raddr1;
    logic [AW-1:0]     raddr2;
    logic              busy1;
    logic              busy2;

    logic [AW-1:0]     ra [NR];
    logic [DW-1:0]     rd [NR];

    logic [NR-1:0]     exp_grant [$];
    logic [AW+DW-1:0]  exp_wr [$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_waddr[i*AW +: AW] = ra[i];
            req_wdata[i*DW +: DW] = rd[i];
        end
    end

    reg_wb_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_waddr   (req_waddr),
        .req_wdata   (req_wdata),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .issue_valid (issue_valid),
        .issue_waddr (issue_waddr),
        .raddr1      (raddr1),
        .raddr2      (raddr2),
        .busy1       (busy1),
        .busy2       (busy2)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [NR-1:0] g, input logic wr, input int unsigned idx);
        exp_grant.push_back(g);
        if (wr) exp_wr.push_back({ra[idx], rd[idx]});
    endtask

    // Monitor: any grant or register-file write must match the next expectation
    initial begin
        logic [NR-1:0]    g;
        logic [AW+DW-1:0] w;
        forever begin
            @(negedge clk);
            if (req_ready != '0) begin
                if (exp_grant.size() == 0) check("unexpected_grant", 64'(req_ready), 64'(0));
                else begin
                    g = exp_grant.pop_front();
                    check("grant", 64'(req_ready), 64'(g));
                end
            end
            if (rf_wen) begin
                if (exp_wr.size() == 0) check("unexpected_rf_wen", 64'(rf_waddr), 64'(0));
                else begin
                    w = exp_wr.pop_front();
                    check("rf_waddr", 64'(rf_waddr), 64'(w[AW+DW-1:DW]));
                    check("rf_wdata", 64'(rf_wdata), 64'(w[DW-1:0]));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned gseq [6] = '{2, 0, 1, 2, 0, 1};
        int unsigned g;

        rst = 1'b1;
        req_valid = '1;
        issue_valid = 1'b0;
        issue_waddr = '0;
        raddr1 = 5'd7;
        raddr2 = 5'd3;
        for (int i = 0; i < NR; i++) begin
            ra[i] = AW'(i + 1);
            rd[i] = 32'h1000 + DW'(i);
        end

        // Reset with all valids asserted
        repeat (2) begin
            @(negedge clk);
            check("rst_ready", 64'(req_ready), 64'(0));
            check("rst_wen", 64'(rf_wen), 64'(0));
            check("rst_busy1", 64'(busy1), 64'(0));
            check("rst_busy2", 64'(busy2), 64'(0));
        end
        tick();
        rst = 1'b0;
        req_valid = '0;

        // Single request from requester 1
        ra[1] = 5'd5;
        rd[1] = 32'hDEADBEEF;
        req_valid = 3'b010;
        push(3'b010, 1'b1, 1);
        tick();
        req_valid = '0;

        // Continuous requests: ptr is 2 after the single transfer
        for (int i = 0; i < NR; i++) begin
            ra[i] = AW'(10 + i);
            rd[i] = 32'hA000_0000 + DW'(i);
        end
        for (int c = 0; c < 6; c++) begin
            g = gseq[c];
            req_valid = '1;
            push(NR'(1 << g), 1'b1, g);
            tick();
            rd[g] = rd[g] + 32'h100;
        end
        req_valid = '0;
        tick();
        tick();

        // Scoreboard set/clear on addr 7 (ptr is 2)
        issue_valid = 1'b1;
        issue_waddr = 5'd7;
        raddr1 = 5'd7;
        raddr2 = 5'd8;
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        check("busy7_set", 64'(busy1), 64'(1));
        check("busy8_clear", 64'(busy2), 64'(0));
        tick();
        @(negedge clk);
        check("busy7_hold", 64'(busy1), 64'(1));
        tick();
        ra[0] = 5'd7;
        rd[0] = 32'h77;
        req_valid = 3'b001;
        push(3'b001, 1'b1, 0);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("busy7_commit_cycle", 64'(busy1), 64'(1));
        tick();
        @(negedge clk);
        check("busy7_cleared", 64'(busy1), 64'(0));

        // Same-edge issue and commit of addr 7 (ptr is 1)
        tick();
        issue_valid = 1'b1;
        issue_waddr = 5'd7;
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        check("busy7_reissued", 64'(busy1), 64'(1));
        tick();
        ra[1] = 5'd7;
        rd[1] = 32'h88;
        req_valid = 3'b010;
        push(3'b010, 1'b1, 1);
        tick();
        req_valid = '0;
        issue_valid = 1'b1;
        issue_waddr = 5'd7;
        tick();
        issue_valid = 1'b0;
        raddr2 = 5'd7;
        @(negedge clk);
        check("busy7_set_wins", 64'(busy1), 64'(1));
        check("busy7_port2", 64'(busy2), 64'(1));

        // Address 0 (ptr is 2)
        tick();
        ra[2] = 5'd0;
        rd[2] = 32'h1234;
        req_valid = 3'b100;
        issue_valid = 1'b1;
        issue_waddr = 5'd0;
        raddr1 = 5'd0;
        raddr2 = 5'd0;
        push(3'b100, 1'b0, 2);
        tick();
        req_valid = '0;
        issue_valid = 1'b0;
        @(negedge clk);
        check("addr0_wen", 64'(rf_wen), 64'(0));
        check("addr0_busy1", 64'(busy1), 64'(0));
        check("addr0_busy2", 64'(busy2), 64'(0));
        tick();
        @(negedge clk);
        check("addr0_wen_later", 64'(rf_wen), 64'(0));

        // Reset mid-operation (ptr is 0, busy[7] still set)
        tick();
        issue_valid = 1'b1;
        issue_waddr = 5'd9;
        tick();
        issue_valid = 1'b0;
        raddr1 = 5'd9;
        raddr2 = 5'd7;
        @(negedge clk);
        check("busy9_set", 64'(busy1), 64'(1));
        tick();
        ra[1] = 5'd20;
        rd[1] = 32'hCAFE;
        req_valid = 3'b010;
        push(3'b010, 1'b1, 1);
        tick();
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        check("busy9_before_rst", 64'(busy1), 64'(1));
        tick();
        rst = 1'b0;
        ra[0] = 5'd21;
        rd[0] = 32'hF00D;
        req_valid = '1;
        push(3'b001, 1'b1, 0);
        @(negedge clk);
        check("midrst_wen", 64'(rf_wen), 64'(0));
        check("midrst_busy9", 64'(busy1), 64'(0));
        check("midrst_busy7", 64'(busy2), 64'(0));
        tick();
        req_valid = '0;
        tick();
        tick();
        @(negedge clk);
        check("grants_drained", 64'(exp_grant.size()), 64'(0));
        check("writes_drained", 64'(exp_wr.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
